// File: rtl/bcd_down_timer_if.sv
// Host-side bundle for bcd_down_timer: load/enable controls in, count and status out.
// The master modport is the host; the slave modport is the timer itself.
interface bcd_down_timer_if #(
    parameter int DIGITS = 2
);
    logic                  en;
    logic                  load;
    logic [4*DIGITS-1:0]   load_val;
    logic [4*DIGITS-1:0]   q;
    logic                  zero;
    logic                  done;
    logic                  busy;

    modport master (
        output en, load, load_val,
        input  q, zero, done, busy
    );

    modport slave (
        input  en, load, load_val,
        output q, zero, done, busy
    );
endinterface

// File: rtl/bcd_down_timer.sv
// Loadable, enable-gated multi-digit BCD down-timer with a one-cycle DONE pulse at expiry.
// Optional auto-reload on expiry is enabled by defining BCD_DOWN_TIMER_RELOAD_EN.
module bcd_down_timer #(
    parameter int DIGITS = 2
) (
    input  logic              clk,
    input  logic              reset_b,
    bcd_down_timer_if.slave   bus
);
    localparam int W = 4 * DIGITS;
    localparam logic [W-1:0] ONE = W'(1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        EXPIRE
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [W-1:0]   q_r;
    logic [W-1:0]   q_next;
    logic [W-1:0]   q_dec;
    logic [W-1:0]   load_clamped;
    logic           dec_borrow;
    logic           done_r;
    logic           done_next;
`ifdef BCD_DOWN_TIMER_RELOAD_EN
    logic [W-1:0]   reload_r;
    logic [W-1:0]   reload_next;
`endif

    // Out-of-range preset digits saturate at 9 so Q only ever holds valid BCD.
    always_comb begin
        load_clamped = '0;
        for (int i = 0; i < DIGITS; i++) begin
            load_clamped[4*i +: 4] = (bus.load_val[4*i +: 4] > 4'd9) ? 4'd9 : bus.load_val[4*i +: 4];
        end
    end

    // Borrow ripples upward through zero digits, each of which wraps to 9.
    always_comb begin
        q_dec      = q_r;
        dec_borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (dec_borrow) begin
                if (q_r[4*i +: 4] == 4'd0) begin
                    q_dec[4*i +: 4] = 4'd9;
                end else begin
                    q_dec[4*i +: 4] = q_r[4*i +: 4] - 4'd1;
                    dec_borrow      = 1'b0;
                end
            end
        end
    end

    always_comb begin
        state_next  = state;
        q_next      = q_r;
        done_next   = 1'b0;
`ifdef BCD_DOWN_TIMER_RELOAD_EN
        reload_next = reload_r;
`endif
        if (bus.load) begin
            q_next     = load_clamped;
            state_next = (load_clamped != '0) ? RUN : IDLE;
`ifdef BCD_DOWN_TIMER_RELOAD_EN
            reload_next = load_clamped;
`endif
        end else begin
            case (state)
                RUN: begin
                    if (bus.en) begin
                        if (q_r == ONE) begin
                            done_next = 1'b1;
`ifdef BCD_DOWN_TIMER_RELOAD_EN
                            q_next     = reload_r;
                            state_next = RUN;
`else
                            q_next     = '0;
                            state_next = EXPIRE;
`endif
                        end else begin
                            q_next = q_dec;
                        end
                    end
                end
                EXPIRE:  state_next = IDLE;
                default: state_next = state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state    <= IDLE;
            q_r      <= '0;
            done_r   <= 1'b0;
`ifdef BCD_DOWN_TIMER_RELOAD_EN
            reload_r <= '0;
`endif
        end else begin
            state    <= state_next;
            q_r      <= q_next;
            done_r   <= done_next;
`ifdef BCD_DOWN_TIMER_RELOAD_EN
            reload_r <= reload_next;
`endif
        end
    end

    assign bus.q    = q_r;
    assign bus.zero = (q_r == '0);
    assign bus.done = done_r;
    assign bus.busy = (state == RUN);
endmodule

// File: tb/tb_bcd_down_timer.sv
// Self-checking bench for bcd_down_timer: directed plan steps plus randomized traffic
// compared against an integer-valued behavioural model of the timer.
module tb_bcd_down_timer;
    localparam int DIGITS = 2;
    localparam int W = 4 * DIGITS;

    logic clk;
    logic reset_b;
    int   numCompared;
    int   numMismatched;

    // Model state: the count as a plain decimal integer plus a running flag.
    int   modelCount;
    int   modelReload;
    bit   modelRunning;
    bit   modelDone;

    bcd_down_timer_if #(.DIGITS(DIGITS)) bus ();

    bcd_down_timer #(.DIGITS(DIGITS)) dut (
        .clk     (clk),
        .reset_b (reset_b),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int bcdToInt(input logic [W-1:0] v);
        int r = 0;
        int m = 1;
        int d;
        for (int i = 0; i < DIGITS; i++) begin
            d = int'(v[4*i +: 4]);
            if (d > 9) d = 9;
            r += d * m;
            m *= 10;
        end
        return r;
    endfunction

    function automatic logic [W-1:0] intToBcd(input int n);
        logic [W-1:0] r = '0;
        int k = n;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(k % 10);
            k = k / 10;
        end
        return r;
    endfunction

    task automatic modelReset();
        modelCount   = 0;
        modelReload  = 0;
        modelRunning = 1'b0;
        modelDone    = 1'b0;
    endtask

    // Applied at each rising edge with the inputs that were sampled there.
    task automatic modelStep();
        int v;
        modelDone = 1'b0;
        if (bus.load) begin
            v            = bcdToInt(bus.load_val);
            modelCount   = v;
            modelReload  = v;
            modelRunning = (v != 0);
        end else if (modelRunning && bus.en) begin
            if (modelCount == 1) begin
                modelDone = 1'b1;
`ifdef BCD_DOWN_TIMER_RELOAD_EN
                modelCount = modelReload;
`else
                modelCount   = 0;
                modelRunning = 1'b0;
`endif
            end else begin
                modelCount = modelCount - 1;
            end
        end
    endtask

    task automatic checkValue(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        numCompared++;
        assert (got === exp) else begin
            numMismatched++;
            $error("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkValue({tag, " q"},    bus.q,          intToBcd(modelCount));
        checkValue({tag, " zero"}, W'(bus.zero),   W'(modelCount == 0));
        checkValue({tag, " done"}, W'(bus.done),   W'(modelDone));
        checkValue({tag, " busy"}, W'(bus.busy),   W'(modelRunning));
    endtask

    // Drive inputs between edges, advance one edge, then sample 1 ns later.
    task automatic applyStimulus(input string tag, input logic l, input logic e, input logic [W-1:0] v);
        bus.load     = l;
        bus.en       = e;
        bus.load_val = v;
        @(posedge clk);
        modelStep();
        #1;
        checkOutput(tag);
    endtask

    initial begin
        logic [W-1:0] seqQ [6];
        logic         seqDone [6];
        logic         sawZero;
        numCompared   = 0;
        numMismatched = 0;
        reset_b       = 1'b1;
        bus.en        = 1'b0;
        bus.load      = 1'b0;
        bus.load_val  = '0;
        modelReset();

        // Asynchronous reset asserted between edges must clear outputs at once.
        #10;
        reset_b = 1'b0;
        #1;
        checkValue("reset q",    bus.q,         8'h00);
        checkValue("reset zero", W'(bus.zero),  W'(1));
        checkValue("reset done", W'(bus.done),  W'(0));
        checkValue("reset busy", W'(bus.busy),  W'(0));
        #11;
        reset_b = 1'b1;

        $display("[TB] load 12 and count to expiry");
        applyStimulus("load12", 1'b1, 1'b1, 8'h12);
        checkValue("load12 q", bus.q, 8'h12);
        for (int k = 11; k >= 1; k--) applyStimulus("count12", 1'b0, 1'b1, 8'h00);
        checkValue("count12 at 01", bus.q, 8'h01);
        applyStimulus("expire12", 1'b0, 1'b1, 8'h00);
`ifndef BCD_DOWN_TIMER_RELOAD_EN
        checkValue("expire12 done", W'(bus.done), W'(1));
        checkValue("expire12 busy", W'(bus.busy), W'(0));
        checkValue("expire12 q",    bus.q,        8'h00);
        applyStimulus("idle12", 1'b0, 1'b1, 8'h00);
        checkValue("idle12 done", W'(bus.done), W'(0));
        checkValue("idle12 q",    bus.q,        8'h00);
        applyStimulus("idle12b", 1'b0, 1'b1, 8'h00);
`endif

        $display("[TB] enable gating");
        applyStimulus("load05", 1'b1, 1'b1, 8'h05);
        applyStimulus("gate", 1'b0, 1'b1, 8'h00);
        applyStimulus("gate", 1'b0, 1'b1, 8'h00);
        checkValue("gate q03", bus.q, 8'h03);
        for (int k = 0; k < 3; k++) applyStimulus("hold", 1'b0, 1'b0, 8'h00);
        checkValue("hold q03", bus.q, 8'h03);
        applyStimulus("resume", 1'b0, 1'b1, 8'h00);
        checkValue("resume q02", bus.q, 8'h02);

        $display("[TB] clamping and zero load");
        applyStimulus("loadAF", 1'b1, 1'b0, 8'hAF);
        checkValue("loadAF q",    bus.q,        8'h99);
        checkValue("loadAF busy", W'(bus.busy), W'(1));
        applyStimulus("load00", 1'b1, 1'b0, 8'h00);
        checkValue("load00 zero", W'(bus.zero), W'(1));
        checkValue("load00 busy", W'(bus.busy), W'(0));
        applyStimulus("load00b", 1'b0, 1'b1, 8'h00);
        checkValue("load00 done", W'(bus.done), W'(0));

        $display("[TB] load overrides enable");
        applyStimulus("load10", 1'b1, 1'b0, 8'h10);
        for (int k = 0; k < 3; k++) applyStimulus("to07", 1'b0, 1'b1, 8'h00);
        checkValue("at07", bus.q, 8'h07);
        applyStimulus("load30", 1'b1, 1'b1, 8'h30);
        checkValue("load30 q", bus.q, 8'h30);
        applyStimulus("dec30", 1'b0, 1'b1, 8'h00);
        checkValue("dec30 q", bus.q, 8'h29);

        $display("[TB] expiry with reload option");
`ifdef BCD_DOWN_TIMER_RELOAD_EN
        seqQ    = '{8'h02, 8'h01, 8'h03, 8'h02, 8'h01, 8'h03};
        seqDone = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
`else
        seqQ    = '{8'h02, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
        seqDone = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
`endif
        sawZero = 1'b0;
        applyStimulus("load03", 1'b1, 1'b1, 8'h03);
        for (int k = 0; k < 6; k++) begin
            applyStimulus("seq03", 1'b0, 1'b1, 8'h00);
            checkValue("seq03 q",    bus.q,        seqQ[k]);
            checkValue("seq03 done", W'(bus.done), W'(seqDone[k]));
            if (bus.zero) sawZero = 1'b1;
        end
`ifdef BCD_DOWN_TIMER_RELOAD_EN
        checkValue("seq03 never zero", W'(sawZero), W'(0));
`else
        checkValue("seq03 reached zero", W'(sawZero), W'(1));
`endif

        $display("[TB] mid-count reset");
        applyStimulus("load45", 1'b1, 1'b1, 8'h45);
        applyStimulus("run45", 1'b0, 1'b1, 8'h00);
        reset_b = 1'b0;
        #1;
        modelReset();
        checkOutput("midreset");
        reset_b = 1'b1;
        for (int k = 0; k < 3; k++) applyStimulus("postreset", 1'b0, 1'b1, 8'h00);

        $display("[TB] randomized traffic");
        for (int k = 0; k < 400; k++) begin
            logic          l;
            logic          e;
            logic [W-1:0]  v;
            l = ($urandom_range(0, 11) == 0);
            e = ($urandom_range(0, 9) < 7);
            v = ($urandom_range(0, 1) == 0) ? W'($urandom_range(0, 8'h15)) : W'($urandom);
            applyStimulus("random", l, e, v);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
        $finish;
    end
endmodule
